// File: rtl/axi4_mgr_sched_if.sv
// axi4_mgr_sched_if: requester-side and manager-side signals of the AXI4 manager scheduler.
interface axi4_mgr_sched_if #(
   parameter int NUM_REQ        = 2,
   parameter int AXI_ADDR_WIDTH = 32,
   parameter int AXI_DATA_WIDTH = 64
);
   logic [NUM_REQ-1:0]                wr_req_i, wr_gnt_o, wr_done_o;
   logic [NUM_REQ-1:0]                rd_req_i, rd_gnt_o, rd_done_o;
   logic [NUM_REQ*AXI_ADDR_WIDTH-1:0] wr_addr_i, rd_addr_i;
   logic [NUM_REQ*AXI_DATA_WIDTH-1:0] wr_data_i;
   logic                              wr_err_o, rd_err_o, spurious_o;
   logic [AXI_DATA_WIDTH-1:0]         rd_data_o, mgr_wr_data_o, mgr_rd_data_i;
   logic [AXI_ADDR_WIDTH-1:0]         mgr_wr_addr_o, mgr_rd_addr_o;
   logic [1:0]                        mgr_req_o, mgr_rsp_i;
   modport slave (
      input  wr_req_i, wr_addr_i, wr_data_i, rd_req_i, rd_addr_i, mgr_rsp_i, mgr_rd_data_i,
      output wr_gnt_o, wr_done_o, wr_err_o, rd_gnt_o, rd_done_o, rd_err_o, rd_data_o,
      output mgr_req_o, mgr_wr_addr_o, mgr_rd_addr_o, mgr_wr_data_o, spurious_o
   );
   modport master (
      output wr_req_i, wr_addr_i, wr_data_i, rd_req_i, rd_addr_i, mgr_rsp_i, mgr_rd_data_i,
      input  wr_gnt_o, wr_done_o, wr_err_o, rd_gnt_o, rd_done_o, rd_err_o, rd_data_o,
      input  mgr_req_o, mgr_wr_addr_o, mgr_rd_addr_o, mgr_wr_data_o, spurious_o
   );
endinterface

// File: rtl/axi4_mgr_sched.sv
// axi4_mgr_sched: shares one single-transaction AXI4 manager among NUM_REQ requesters via independent round-robin write/read channels.
module axi4_mgr_sched #(
   parameter int NUM_REQ        = 2,
   parameter int AXI_ADDR_WIDTH = 32,
   parameter int AXI_DATA_WIDTH = 64,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input logic             clk_i,
   input logic             rst_i,
   axi4_mgr_sched_if.slave bus
);
   localparam int AW = AXI_ADDR_WIDTH;
   localparam int DW = AXI_DATA_WIDTH;
   localparam int IW = $clog2(NUM_REQ);
   localparam int CW = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CW-1:0] TMAX = CW'(TIMEOUT_CYCLES > 0 ? TIMEOUT_CYCLES - 1 : 0);
   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;
   logic [NUM_REQ-1:0]    req [2];
   logic [NUM_REQ*AW-1:0] addr_in [2];
   logic [NUM_REQ-1:0]    gnt [2];
   logic [1:0]            busy;
   logic                  spurious_q;
   assign req[0]     = bus.wr_req_i;
   assign req[1]     = bus.rd_req_i;
   assign addr_in[0] = bus.wr_addr_i;
   assign addr_in[1] = bus.rd_addr_i;
   for (genvar c = 0; c < 2; c++) begin : g_ch
      state_e             state_q;
      logic [IW-1:0]      ptr_q, idx_q, win;
      logic [CW-1:0]      cnt_q;
      logic               any, req_q, err_q;
      logic [NUM_REQ-1:0] done_q;
      logic [AW-1:0]      addr_q;
      logic [DW-1:0]      data_q;
      // Scan downwards so the requester closest to ptr_q is the last (winning) assignment.
      always_comb begin
         win = ptr_q;
         any = 1'b0;
         for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req[c][(int'(ptr_q) + k) % NUM_REQ]) begin
               win = IW'((int'(ptr_q) + k) % NUM_REQ);
               any = 1'b1;
            end
         end
      end
      assign gnt[c]  = (!rst_i && state_q == IDLE && any) ? NUM_REQ'(1) << win : '0;
      assign busy[c] = state_q == BUSY;
      always_ff @(posedge clk_i or posedge rst_i)
         if (rst_i) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            req_q   <= 1'b0;
            err_q   <= 1'b0;
            done_q  <= '0;
            addr_q  <= '0;
            data_q  <= '0;
         end else begin
            done_q <= '0;
            case (state_q)
               IDLE: if (any) begin
                  idx_q   <= win;
                  ptr_q   <= win == IW'(NUM_REQ - 1) ? '0 : win + 1'b1;
                  addr_q  <= addr_in[c][int'(win)*AW +: AW];
                  if (c == 0) data_q <= bus.wr_data_i[int'(win)*DW +: DW];
                  req_q   <= 1'b1;
                  cnt_q   <= '0;
                  state_q <= BUSY;
               end
               BUSY: begin
                  cnt_q <= cnt_q + 1'b1;
                  if (bus.mgr_rsp_i[c] || (TIMEOUT_CYCLES != 0 && cnt_q == TMAX)) begin
                     req_q   <= 1'b0;
                     err_q   <= !bus.mgr_rsp_i[c];
                     done_q  <= NUM_REQ'(1) << idx_q;
                     state_q <= DONE;
                     if (c == 1 && bus.mgr_rsp_i[c]) data_q <= bus.mgr_rd_data_i;
                  end
               end
               default: begin
                  err_q   <= 1'b0;
                  state_q <= IDLE;
               end
            endcase
         end
   end
   always_ff @(posedge clk_i or posedge rst_i)
      if (rst_i) spurious_q <= 1'b0;
      else       spurious_q <= spurious_q | (|(bus.mgr_rsp_i & ~busy));
   assign bus.wr_gnt_o      = gnt[0];
   assign bus.rd_gnt_o      = gnt[1];
   assign bus.wr_done_o     = g_ch[0].done_q;
   assign bus.rd_done_o     = g_ch[1].done_q;
   assign bus.wr_err_o      = g_ch[0].err_q;
   assign bus.rd_err_o      = g_ch[1].err_q;
   assign bus.rd_data_o     = g_ch[1].data_q;
   assign bus.mgr_req_o     = {g_ch[1].req_q, g_ch[0].req_q};
   assign bus.mgr_wr_addr_o = g_ch[0].addr_q;
   assign bus.mgr_rd_addr_o = g_ch[1].addr_q;
   assign bus.mgr_wr_data_o = g_ch[0].data_q;
   assign bus.spurious_o    = spurious_q;
endmodule

// File: tb/tb_axi4_mgr_sched.sv
// tb_axi4_mgr_sched: directed self-checking bench for axi4_mgr_sched with three requesters and an 8-cycle timeout.
module tb_axi4_mgr_sched;
   localparam int N  = 3;
   localparam int AW = 32;
   localparam int DW = 64;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;
   always #5 clk = ~clk;
   axi4_mgr_sched_if #(.NUM_REQ(N), .AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW)) bus ();
   axi4_mgr_sched #(.NUM_REQ(N), .AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW), .TIMEOUT_CYCLES(8))
      dut (.clk_i(clk), .rst_i(rst), .bus(bus));

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.wr_req_i      = '0;
      bus.rd_req_i      = '0;
      bus.mgr_rsp_i     = '0;
      bus.mgr_rd_data_i = '0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      idle_inputs();
      bus.wr_addr_i = '0;
      bus.rd_addr_i = '0;
      bus.wr_data_i = '0;
      bus.wr_req_i  = '1;
      bus.rd_req_i  = '1;
      @(negedge clk);
      checks++; if (bus.wr_gnt_o !== 3'b000 || bus.rd_gnt_o !== 3'b000) begin errors++; $display("FAIL reset_gnt: got wr %b rd %b, want 000 000", bus.wr_gnt_o, bus.rd_gnt_o); end
      checks++; if (bus.mgr_req_o !== 2'b00) begin errors++; $display("FAIL reset_mgr_req: got %b, want 00", bus.mgr_req_o); end
      checks++; if ({bus.wr_done_o, bus.rd_done_o, bus.wr_err_o, bus.rd_err_o, bus.spurious_o} !== 9'b0) begin errors++; $display("FAIL reset_status: got done %b/%b err %b/%b spur %b, want all 0", bus.wr_done_o, bus.rd_done_o, bus.wr_err_o, bus.rd_err_o, bus.spurious_o); end
      checks++; if (bus.mgr_wr_addr_o !== 32'h0 || bus.mgr_wr_data_o !== 64'h0 || bus.rd_data_o !== 64'h0) begin errors++; $display("FAIL reset_bus: got addr %h data %h rd_data %h, want 0", bus.mgr_wr_addr_o, bus.mgr_wr_data_o, bus.rd_data_o); end
      cyc();
      rst = 1'b0;
      idle_inputs();
   endtask

   task automatic test_single_write();
      cyc();
      bus.wr_addr_i[0 +: AW] = 32'h5000;
      bus.wr_data_i[0 +: DW] = 64'hDEADBEEF0B501E7E;
      bus.wr_req_i           = 3'b001;
      @(negedge clk);
      checks++; if (bus.wr_gnt_o !== 3'b001) begin errors++; $display("FAIL single_gnt: got %b, want 001", bus.wr_gnt_o); end
      cyc();
      bus.wr_req_i = '0;
      for (int c = 1; c <= 4; c++) begin
         if (c == 4) bus.mgr_rsp_i = 2'b01;
         @(negedge clk);
         checks++; if (bus.mgr_req_o !== 2'b01 || bus.mgr_wr_addr_o !== 32'h5000 || bus.mgr_wr_data_o !== 64'hDEADBEEF0B501E7E || bus.wr_done_o !== 3'b000) begin errors++; $display("FAIL single_busy c%0d: got req %b addr %h data %h done %b, want 01 5000 deadbeef0b501e7e 000", c, bus.mgr_req_o, bus.mgr_wr_addr_o, bus.mgr_wr_data_o, bus.wr_done_o); end
         cyc();
      end
      bus.mgr_rsp_i = '0;
      @(negedge clk);
      checks++; if (bus.wr_done_o !== 3'b001 || bus.wr_err_o !== 1'b0) begin errors++; $display("FAIL single_done: got done %b err %b, want 001 0", bus.wr_done_o, bus.wr_err_o); end
      checks++; if (bus.mgr_req_o !== 2'b00) begin errors++; $display("FAIL single_req_drop: got %b, want 00", bus.mgr_req_o); end
      cyc();
      @(negedge clk);
      checks++; if (bus.wr_done_o !== 3'b000) begin errors++; $display("FAIL single_done_pulse: got %b, want 000", bus.wr_done_o); end
   endtask

   task automatic test_concurrent();
      cyc();
      bus.rd_addr_i[AW +: AW] = 32'h6000;
      bus.wr_req_i            = 3'b001;
      bus.rd_req_i            = 3'b010;
      @(negedge clk);
      checks++; if (bus.wr_gnt_o !== 3'b001 || bus.rd_gnt_o !== 3'b010) begin errors++; $display("FAIL conc_gnt: got wr %b rd %b, want 001 010", bus.wr_gnt_o, bus.rd_gnt_o); end
      cyc();
      bus.wr_req_i      = '0;
      bus.rd_req_i      = '0;
      bus.mgr_rsp_i     = 2'b10;
      bus.mgr_rd_data_i = 64'h1234;
      @(negedge clk);
      checks++; if (bus.mgr_req_o !== 2'b11 || bus.mgr_rd_addr_o !== 32'h6000) begin errors++; $display("FAIL conc_req: got req %b rd_addr %h, want 11 6000", bus.mgr_req_o, bus.mgr_rd_addr_o); end
      cyc();
      bus.mgr_rsp_i     = 2'b01;
      bus.mgr_rd_data_i = '0;
      @(negedge clk);
      checks++; if (bus.rd_done_o !== 3'b010 || bus.rd_data_o !== 64'h1234 || bus.rd_err_o !== 1'b0) begin errors++; $display("FAIL conc_rd_done: got done %b data %h err %b, want 010 1234 0", bus.rd_done_o, bus.rd_data_o, bus.rd_err_o); end
      checks++; if (bus.wr_done_o !== 3'b000 || bus.mgr_req_o !== 2'b01) begin errors++; $display("FAIL conc_wr_busy: got done %b req %b, want 000 01", bus.wr_done_o, bus.mgr_req_o); end
      cyc();
      bus.mgr_rsp_i = '0;
      @(negedge clk);
      checks++; if (bus.wr_done_o !== 3'b001 || bus.wr_err_o !== 1'b0 || bus.rd_done_o !== 3'b000 || bus.mgr_req_o !== 2'b00) begin errors++; $display("FAIL conc_wr_done: got wr_done %b err %b rd_done %b req %b, want 001 0 000 00", bus.wr_done_o, bus.wr_err_o, bus.rd_done_o, bus.mgr_req_o); end
      cyc();
   endtask

   task automatic test_round_robin();
      logic [N-1:0] exp;
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      bus.wr_req_i = 3'b111;
      for (int g = 0; g < 4; g++) begin
         exp = N'(1) << (g % N);
         @(negedge clk);
         checks++; if (bus.wr_gnt_o !== exp) begin errors++; $display("FAIL rr_gnt #%0d: got %b, want %b", g, bus.wr_gnt_o, exp); end
         cyc();
         bus.mgr_rsp_i = 2'b01;
         cyc();
         bus.mgr_rsp_i = '0;
         @(negedge clk);
         checks++; if (bus.wr_done_o !== exp) begin errors++; $display("FAIL rr_done #%0d: got %b, want %b", g, bus.wr_done_o, exp); end
         cyc();
      end
      bus.wr_req_i = '0;
   endtask

   task automatic test_timeout();
      int bad = 0;
      bus.wr_req_i = 3'b010;
      @(negedge clk);
      checks++; if (bus.wr_gnt_o !== 3'b010) begin errors++; $display("FAIL to_gnt: got %b, want 010", bus.wr_gnt_o); end
      for (int c = 1; c <= 8; c++) begin
         cyc();
         if (c == 1) bus.wr_req_i = '0;
         @(negedge clk);
         if (bus.mgr_req_o[0] !== 1'b1 || bus.wr_done_o !== 3'b000) bad++;
      end
      checks++; if (bad != 0) begin errors++; $display("FAIL to_wait: got %0d bad cycles of req/done, want 0", bad); end
      cyc();
      @(negedge clk);
      checks++; if (bus.wr_done_o !== 3'b010 || bus.wr_err_o !== 1'b1) begin errors++; $display("FAIL to_done: got done %b err %b, want 010 1", bus.wr_done_o, bus.wr_err_o); end
      checks++; if (bus.mgr_req_o[0] !== 1'b0) begin errors++; $display("FAIL to_req_drop: got %b, want 0", bus.mgr_req_o[0]); end
      cyc();
      bus.wr_req_i = 3'b100;
      @(negedge clk);
      checks++; if (bus.wr_gnt_o !== 3'b100) begin errors++; $display("FAIL to_next_gnt: got %b, want 100", bus.wr_gnt_o); end
      cyc();
      bus.wr_req_i  = '0;
      bus.mgr_rsp_i = 2'b01;
      cyc();
      bus.mgr_rsp_i = '0;
      @(negedge clk);
      checks++; if (bus.wr_done_o !== 3'b100 || bus.wr_err_o !== 1'b0) begin errors++; $display("FAIL to_next_done: got done %b err %b, want 100 0", bus.wr_done_o, bus.wr_err_o); end
      cyc();
   endtask

   task automatic test_spurious_race();
      @(negedge clk);
      checks++; if (bus.spurious_o !== 1'b0) begin errors++; $display("FAIL spur_clear: got %b, want 0", bus.spurious_o); end
      cyc();
      bus.mgr_rsp_i = 2'b10;
      cyc();
      bus.mgr_rsp_i = '0;
      @(negedge clk);
      checks++; if (bus.spurious_o !== 1'b1 || bus.rd_done_o !== 3'b000) begin errors++; $display("FAIL spur_set: got spur %b rd_done %b, want 1 000", bus.spurious_o, bus.rd_done_o); end
      cyc();
      cyc();
      @(negedge clk);
      checks++; if (bus.spurious_o !== 1'b1 || bus.rd_done_o !== 3'b000) begin errors++; $display("FAIL spur_sticky: got spur %b rd_done %b, want 1 000", bus.spurious_o, bus.rd_done_o); end
      cyc();
      bus.wr_req_i = 3'b001;
      @(negedge clk);
      checks++; if (bus.wr_gnt_o !== 3'b001) begin errors++; $display("FAIL race_gnt: got %b, want 001", bus.wr_gnt_o); end
      for (int c = 1; c <= 8; c++) begin
         cyc();
         if (c == 1) bus.wr_req_i = '0;
         if (c == 8) bus.mgr_rsp_i = 2'b01;
      end
      cyc();
      bus.mgr_rsp_i = '0;
      @(negedge clk);
      checks++; if (bus.wr_done_o !== 3'b001 || bus.wr_err_o !== 1'b0) begin errors++; $display("FAIL race_done: got done %b err %b, want 001 0", bus.wr_done_o, bus.wr_err_o); end
      cyc();
   endtask

   task automatic test_reset_busy();
      int bad = 0;
      bus.wr_req_i = 3'b010;
      @(negedge clk);
      checks++; if (bus.wr_gnt_o !== 3'b010) begin errors++; $display("FAIL rstb_gnt: got %b, want 010", bus.wr_gnt_o); end
      cyc();
      bus.wr_req_i = '0;
      cyc();
      checks++; if (bus.mgr_req_o !== 2'b01) begin errors++; $display("FAIL rstb_busy: got %b, want 01", bus.mgr_req_o); end
      rst = 1'b1;
      #1;
      checks++; if (bus.mgr_req_o !== 2'b00 || bus.mgr_wr_addr_o !== 32'h0) begin errors++; $display("FAIL rstb_async: got req %b addr %h, want 00 0", bus.mgr_req_o, bus.mgr_wr_addr_o); end
      repeat (3) begin
         @(negedge clk);
         if (bus.wr_done_o !== 3'b000 || bus.wr_err_o !== 1'b0) bad++;
      end
      checks++; if (bad != 0) begin errors++; $display("FAIL rstb_no_done: got %0d cycles with done/err, want 0", bad); end
      cyc();
      rst = 1'b0;
      bus.wr_req_i = 3'b111;
      @(negedge clk);
      checks++; if (bus.wr_gnt_o !== 3'b001) begin errors++; $display("FAIL rstb_ptr: got %b, want 001", bus.wr_gnt_o); end
      cyc();
      bus.wr_req_i  = '0;
      bus.mgr_rsp_i = 2'b01;
      cyc();
      bus.mgr_rsp_i = '0;
      @(negedge clk);
      checks++; if (bus.wr_done_o !== 3'b001 || bus.wr_err_o !== 1'b0) begin errors++; $display("FAIL rstb_done: got done %b err %b, want 001 0", bus.wr_done_o, bus.wr_err_o); end
      cyc();
   endtask

   initial begin
      test_reset();
      test_single_write();
      test_concurrent();
      test_round_robin();
      test_timeout();
      test_spurious_race();
      test_reset_busy();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
